// File: rtl/multicycle_control_fsm.sv
// Multicycle RISC-V control unit.
// Steps each instruction through fetch/decode/execute/memory/writeback and
// drives the datapath mux selects, write enables and the ALU operation.
// Only the state is registered. Every output is decoded combinationally from
// the state and the instruction fields, so beq can resolve in the same cycle.
module multicycle_control_fsm #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [6:0]         opcode,
  input  logic [2:0]         funct3,
  input  logic               funct7_5,
  input  logic               zero_flag,
  output logic               pc_write,
  output logic               adr_src,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_write,
  output logic [1:0]         result_src,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [2:0]         alu_sel,
  output logic [1:0]         imm_src,
  output logic [STATE_W-1:0] state
);

  // Opcodes recognised by the decoder
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // ALU operation codes
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Result mux selects
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // ALU A mux selects
  localparam logic [1:0] A_PC    = 2'b00;
  localparam logic [1:0] A_OLDPC = 2'b01;
  localparam logic [1:0] A_RS1   = 2'b10;

  // ALU B mux selects
  localparam logic [1:0] B_RS2  = 2'b00;
  localparam logic [1:0] B_IMM  = 2'b01;
  localparam logic [1:0] B_FOUR = 2'b10;

  // Immediate formats
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = STATE_W'(0),
    S_DECODE   = STATE_W'(1),
    S_MEMADR   = STATE_W'(2),
    S_MEMREAD  = STATE_W'(3),
    S_MEMWB    = STATE_W'(4),
    S_MEMWRITE = STATE_W'(5),
    S_EXECR    = STATE_W'(6),
    S_ALUWB    = STATE_W'(7),
    S_EXECI    = STATE_W'(8),
    S_JAL      = STATE_W'(9),
    S_BEQ      = STATE_W'(10)
  } state_e;

  state_e state_q, state_d;

  // ALU op for register and immediate arithmetic. Only the R-type form of
  // funct3=000 can subtract; for addi bit 30 belongs to the immediate.
  function automatic logic [2:0] funct_alu(input logic [6:0] op,
                                           input logic [2:0] f3,
                                           input logic       f7_5);
    logic [2:0] sel;
    sel = ALU_ADD;
    case (f3)
      3'b000:  sel = (op == OP_RTYPE && f7_5) ? ALU_SUB : ALU_ADD;
      3'b010:  sel = ALU_SLT;
      3'b110:  sel = ALU_OR;
      3'b111:  sel = ALU_AND;
      default: sel = ALU_ADD;
    endcase
    return sel;
  endfunction

  // Immediate format follows the opcode alone, independent of state
  function automatic logic [1:0] imm_fmt(input logic [6:0] op);
    logic [1:0] fmt;
    case (op)
      OP_STORE:  fmt = IMM_S;
      OP_BRANCH: fmt = IMM_B;
      OP_JAL:    fmt = IMM_J;
      default:   fmt = IMM_I;
    endcase
    return fmt;
  endfunction

  // State register; reset lands in FETCH and abandons any instruction
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Next-state selection
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD,
          OP_STORE:  state_d = S_MEMADR;
          OP_RTYPE:  state_d = S_EXECR;
          OP_ITYPE:  state_d = S_EXECI;
          OP_JAL:    state_d = S_JAL;
          OP_BRANCH: state_d = S_BEQ;
          default:   state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_BEQ:      state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  // Datapath controls; every output starts at 0 and each state raises only
  // what it needs. Write enables are masked while reset is held.
  always_comb begin
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = A_PC;
    alu_src_b  = B_RS2;
    alu_sel    = ALU_ADD;
    imm_src    = imm_fmt(opcode);

    case (state_q)
      S_FETCH: begin
        adr_src    = 1'b0;
        ir_write   = 1'b1;
        alu_src_a  = A_PC;
        alu_src_b  = B_FOUR;
        alu_sel    = ALU_ADD;
        result_src = RES_ALU;
        pc_write   = 1'b1;
      end
      S_DECODE: begin
        // Branch/jump target is computed here and parked in ALUOut
        alu_src_a = A_OLDPC;
        alu_src_b = B_IMM;
        alu_sel   = ALU_ADD;
      end
      S_MEMADR: begin
        alu_src_a = A_RS1;
        alu_src_b = B_IMM;
        alu_sel   = ALU_ADD;
      end
      S_MEMREAD: begin
        result_src = RES_ALUOUT;
        adr_src    = 1'b1;
      end
      S_MEMWB: begin
        result_src = RES_MEM;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        result_src = RES_ALUOUT;
        adr_src    = 1'b1;
        mem_write  = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = A_RS1;
        alu_src_b = B_RS2;
        alu_sel   = funct_alu(opcode, funct3, funct7_5);
      end
      S_EXECI: begin
        alu_src_a = A_RS1;
        alu_src_b = B_IMM;
        alu_sel   = funct_alu(opcode, funct3, funct7_5);
      end
      S_ALUWB: begin
        result_src = RES_ALUOUT;
        reg_write  = 1'b1;
      end
      S_JAL: begin
        // PC takes the target from ALUOut while the ALU forms oldPC+4
        alu_src_a  = A_OLDPC;
        alu_src_b  = B_FOUR;
        alu_sel    = ALU_ADD;
        result_src = RES_ALUOUT;
        pc_write   = 1'b1;
      end
      S_BEQ: begin
        // rs1-rs2 compare; zero_flag decides the PC load in this same cycle
        alu_src_a  = A_RS1;
        alu_src_b  = B_RS2;
        alu_sel    = ALU_SUB;
        result_src = RES_ALUOUT;
        pc_write   = zero_flag;
      end
      default: begin
        // Unreachable encodings drive nothing at all
        imm_src = IMM_I;
      end
    endcase

    if (rst) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
    end
  end

  assign state = state_q;

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Multicycle RISC-V control unit. It sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives the 3-bit ALU operation select consumed by the ALU. Consumes the ALU's zero_flag to resolve beq.
- Supports lw, sw, R-type (add/sub/and/or/slt), I-type ALU ops, beq and jal.
- opcode/funct inputs come from the datapath instruction register and are stable from DECODE until the next FETCH.

Parameters:
- STATE_W, 4, width of state register and state debug port.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- opcode  in  7  instruction[6:0].
- funct3  in  3  instruction[14:12].
- funct7_5  in  1  instruction[30].
- zero_flag  in  1  ALU result == 0.
- pc_write  out  1  PC load enable.
- adr_src  out  1  memory address select: 0=PC, 1=ALUOut.
- mem_write  out  1  data memory write enable.
- ir_write  out  1  instruction register load enable.
- reg_write  out  1  register file write enable.
- result_src  out  2  result mux: 00=ALUOut, 01=mem data, 10=ALU result direct.
- alu_src_a  out  2  ALU A mux: 00=PC, 01=oldPC, 10=rs1.
- alu_src_b  out  2  ALU B mux: 00=rs2, 01=imm, 10=const 4.
- alu_sel  out  3  ALU op: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- imm_src  out  2  immediate format: 00 I, 01 S, 10 B, 11 J.
- state  out  STATE_W  current state (debug).

Behaviour:
- Encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, ALUWB=7, EXECI=8, JAL=9, BEQ=10.
- Registered: state only.
- Combinational outputs: all outputs are combinational from state, opcode, funct3, funct7_5 and zero_flag.
- Default value of any output not listed for a state is 0.
- Reset: with rst high at a clock edge, state becomes FETCH.
  - While rst is high, pc_write, ir_write, mem_write and reg_write are forced to 0 regardless of state.
  - Reset mid-instruction abandons the instruction; no partial writes occur after reset asserts.
- FETCH: adr_src=0, ir_write=1, alu_src_a=00, alu_src_b=10, alu_sel=000, result_src=10, pc_write=1. Next: DECODE.
- DECODE: alu_src_a=01, alu_src_b=01, alu_sel=000 (branch/jump target into ALUOut). Next by opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1101111 -> JAL
  - 1100011 -> BEQ
  - any other opcode -> FETCH (illegal opcode: no enable asserted)
- MEMADR: alu_src_a=10, alu_src_b=01, alu_sel=000. Next: MEMREAD if opcode=0000011, else MEMWRITE.
- MEMREAD: result_src=00, adr_src=1. Next: MEMWB.
- MEMWB: result_src=01, reg_write=1. Next: FETCH.
- MEMWRITE: result_src=00, adr_src=1, mem_write=1. Next: FETCH.
- EXECR: alu_src_a=10, alu_src_b=00, alu_sel from funct decode. Next: ALUWB.
- EXECI: alu_src_a=10, alu_src_b=01, alu_sel from funct decode. Next: ALUWB.
- ALUWB: result_src=00, reg_write=1. Next: FETCH.
- JAL: alu_src_a=01, alu_src_b=10, alu_sel=000, result_src=00, pc_write=1. Next: ALUWB (writes PC+4 to rd).
- BEQ: alu_src_a=10, alu_src_b=00, alu_sel=001, result_src=00, pc_write=zero_flag (Mealy, same cycle). Next: FETCH.
- Funct decode (EXECR/EXECI only), by funct3:
  - 000 -> 001 if opcode=0110011 and funct7_5=1, else 000
  - 010 -> 101
  - 110 -> 011
  - 111 -> 010
  - all other funct3 -> 000
- imm_src decoded from opcode in every state:
  - 0100011 -> 01
  - 1100011 -> 10
  - 1101111 -> 11
  - all others -> 00
- Unused state encodings 11-15: all outputs 0; next state FETCH.
- Latency (cycles per instruction): lw 5, sw 4, R/I 4, jal 4, beq 3, illegal 2.

Test Plan:
- Reset: assert rst for 2 cycles while in EXECR -> write enables 0 during reset; state=0 after the edge. Cycle after release: ir_write=1, pc_write=1, alu_sel=000, alu_src_b=10.
- lw (opcode 0000011) -> state sequence 0,1,2,3,4,0. adr_src=1 only in state 3; reg_write=1 with result_src=01 only in state 4; imm_src=00. sw (0100011) -> 0,1,2,5,0, mem_write=1 only in state 5, imm_src=01.
- R-type funct sweep, opcode 0110011, in EXECR:
  - funct3=000, funct7_5=1 -> alu_sel=001
  - funct3=000, funct7_5=0 -> 000
  - funct3=111 -> 010
  - funct3=110 -> 011
  - funct3=010 -> 101
  - funct3=100 -> 000
- I-type: opcode 0010011, funct3=000, funct7_5=1 -> EXECI alu_sel=000 (no sub), alu_src_b=01, then ALUWB reg_write=1.
- beq (1100011), sequence 0,1,10,0, alu_sel=001 in BEQ:
  - zero_flag=1 -> pc_write=1
  - zero_flag=0 -> pc_write=0
  - zero_flag toggled mid-cycle -> pc_write follows combinationally
- jal (1101111) -> sequence 0,1,9,7,0, pc_write=1 in state 9, reg_write=1 in state 7, imm_src=11. Illegal opcode 0000000 -> sequence 0,1,0, no mem_write/reg_write asserted.
